timer_ctrl: RTL

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_pkg.sv | 15 +
 rtl/timer_prescaler.sv | 30 +++
 rtl/timer_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared types and default widths for the timer controller.
// Used by timer_ctrl and timer_prescaler.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_PS_WIDTH = 4;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable tick divider: one tick every div+1 enabled cycles.
// Instantiated by timer_ctrl only when TIMER_CTRL_PRESCALER_EN is defined.
module timer_prescaler
    import timer_ctrl_pkg::*;
#(
    parameter int PS_WIDTH = DEF_PS_WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                en,
    input  logic [PS_WIDTH-1:0] div,
    output logic                tick
);

    logic [PS_WIDTH-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Start/stop/pause timer with one-shot or periodic terminal count.
// Define TIMER_CTRL_PRESCALER_EN to build in the prescaler.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PS_WIDTH = DEF_PS_WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                periodic,
    input  logic [WIDTH-1:0]    limit,
    input  logic [PS_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                done
);

    state_t             state;
    logic [WIDTH-1:0]   limit_q;
    logic               periodic_q;
    logic               run;
    logic               tick;

    // A RUN cycle with pause high is the transition cycle, so it never counts.
    assign run = (state == RUN) && !pause;

`ifdef TIMER_CTRL_PRESCALER_EN
    logic [PS_WIDTH-1:0] prescale_q;

    timer_prescaler #(
        .PS_WIDTH (PS_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start || stop),
        .en      (run),
        .div     (prescale_q),
        .tick    (tick)
    );
`else
    logic unused_prescale;

    assign unused_prescale = ^prescale;
    assign tick            = run;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            limit_q    <= '0;
            periodic_q <= 1'b0;
`ifdef TIMER_CTRL_PRESCALER_EN
            prescale_q <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
                count <= '0;
                busy  <= 1'b0;
            end else if (start) begin
                state      <= RUN;
                count      <= '0;
                busy       <= 1'b1;
                limit_q    <= limit;
                periodic_q <= periodic;
`ifdef TIMER_CTRL_PRESCALER_EN
                prescale_q <= prescale;
`endif
            end else begin
                unique case (state)
                    RUN: begin
                        if (pause) begin
                            state <= PAUSED;
                        end else if (tick) begin
                            if (count == limit_q) begin
                                done <= 1'b1;
                                if (periodic_q) begin
                                    count <= '0;
                                end else begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                    PAUSED: begin
                        if (!pause) state <= RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
